fixed_point_sqrt_seq: RTL and testbench



---
 rtl/fixed_point_sqrt_seq_if.sv | 22 ++
 rtl/fixed_point_sqrt_seq.sv | 129 ++++++++++++
 tb/tb_fixed_point_sqrt_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fixed_point_sqrt_seq_if.sv
// Operand and result valid/ready channels of the Q8.4 sequential square-root unit.
interface fixed_point_sqrt_seq_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_root;
    logic             out_neg;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_root, out_neg
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_root, out_neg
    );
endinterface

// File: rtl/fixed_point_sqrt_seq.sv
// Sequential Q8.4 floor(sqrt): restoring digit-by-digit integer root, two
// radicand bits per cycle, negative operands flagged and returned as zero.
module fixed_point_sqrt_seq #(
    parameter int WIDTH = 12,
    parameter int FRAC  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_point_sqrt_seq_if.slave  bus,
    output logic                   busy
);
    localparam int RAD_W = ((WIDTH + FRAC + 1) / 2) * 2;
    localparam int ITER  = RAD_W / 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [RAD_W-1:0]   rad_q;
    logic [ITER+1:0]    rem_q;
    logic [ITER-1:0]    root_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_root_q;
    logic               out_neg_q;
    logic               busy_q;

    logic [1:0]         rad_top_s;
    logic [ITER+3:0]    shifted_s;
    logic [ITER+3:0]    subtrahend_s;
    logic [ITER+3:0]    trial_s;
    logic               trial_ok_s;
    logic [ITER+3:0]    rem_full_s;
    logic [ITER+1:0]    rem_next_s;
    logic [ITER-1:0]    root_next_s;
    logic [1:0]         unused_rem_hi_s;

    // One restoring iteration: try subtracting {root,01} from the shifted remainder
    always_comb begin
        rad_top_s    = rad_q[RAD_W-1 -: 2];
        shifted_s    = {rem_q, rad_top_s};
        subtrahend_s = {2'b00, root_q, 2'b01};
        trial_s      = shifted_s - subtrahend_s;
        trial_ok_s   = (shifted_s >= subtrahend_s);
        if (trial_ok_s) begin
            rem_full_s = trial_s;
        end else begin
            rem_full_s = shifted_s;
        end
        // The remainder never exceeds 2*root, so the top two bits are always zero
        rem_next_s      = rem_full_s[ITER+1:0];
        unused_rem_hi_s = rem_full_s[ITER+3:ITER+2];
        root_next_s     = {root_q[ITER-2:0], trial_ok_s};
    end

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        rad_q      <= RAD_W'(bus.in_a[WIDTH-2:0]) << FRAC;
                        rem_q      <= '0;
                        root_q     <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.in_a[WIDTH-1]) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_root_q  <= '0;
                            out_neg_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_next_s;
                    root_q <= root_next_s;
                    rad_q  <= rad_q << 2;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_root_q  <= WIDTH'(root_next_s);
                        out_neg_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_root  = out_root_q;
    assign bus.out_neg   = out_neg_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_fixed_point_sqrt_seq.sv
// Directed vector bench for fixed_point_sqrt_seq: table of Q8.4 operands with
// hand-computed roots, plus backpressure and mid-operation reset sequences.
module tb_fixed_point_sqrt_seq;
    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_bad;

    fixed_point_sqrt_seq_if #(.WIDTH(12)) bus_if ();

    fixed_point_sqrt_seq #(.WIDTH(12), .FRAC(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] root;
        logic        neg;
        int          lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // lat = clock edges after the accept edge until out_valid is seen
    task automatic run_op(input logic [11:0] a, input logic [11:0] exp_root,
                          input logic exp_neg, input int exp_lat);
        int lat;
        check("in_ready_before", int'(bus_if.in_ready), 1);
        bus_if.in_a      = a;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("out_root", int'(bus_if.out_root), int'(exp_root));
        check("out_neg", int'(bus_if.out_neg), int'(exp_neg));
        @(posedge clk);
        #1;
        check("in_ready_after", int'(bus_if.in_ready), 1);
        check("out_valid_after", int'(bus_if.out_valid), 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   seen;
        int   lat;

        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{12'h040, 12'h020, 1'b0, 8};
        vecs[1] = '{12'h190, 12'h050, 1'b0, 8};
        vecs[2] = '{12'h020, 12'h016, 1'b0, 8};
        vecs[3] = '{12'h7FF, 12'h0B4, 1'b0, 8};
        vecs[4] = '{12'h001, 12'h004, 1'b0, 8};
        vecs[5] = '{12'h000, 12'h000, 1'b0, 8};
        vecs[6] = '{12'h800, 12'h000, 1'b1, 0};
        vecs[7] = '{12'hFF0, 12'h000, 1'b1, 0};
        vecs[8] = '{12'h100, 12'h040, 1'b0, 8};

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = 12'h000;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", int'(bus_if.in_ready), 1);
        check("rst_out_valid", int'(bus_if.out_valid), 0);
        check("rst_out_root", int'(bus_if.out_root), 0);
        check("rst_out_neg", int'(bus_if.out_neg), 0);
        check("rst_busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].root, vecs[i].neg, vecs[i].lat);
        end

        // Backpressure with an ignored in_valid pulse during CALC
        bus_if.in_a      = 12'h190;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("bp_busy", int'(busy), 1);
        repeat (3) @(posedge clk);
        #1;
        bus_if.in_a     = 12'h040;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 4;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", int'(bus_if.out_valid), 1);
            check("bp_hold_root", int'(bus_if.out_root), 12'h050);
            check("bp_hold_neg", int'(bus_if.out_neg), 0);
            check("bp_hold_in_ready", int'(bus_if.in_ready), 0);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", int'(bus_if.in_ready), 1);
        check("bp_release_valid", int'(bus_if.out_valid), 0);

        // Reset four cycles into CALC aborts with no result
        bus_if.in_a     = 12'h040;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", int'(bus_if.in_ready), 1);
        check("mid_rst_out_valid", int'(bus_if.out_valid), 0);
        check("mid_rst_out_root", int'(bus_if.out_root), 0);
        check("mid_rst_out_neg", int'(bus_if.out_neg), 0);
        check("mid_rst_busy", int'(busy), 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) seen++;
        end
        check("mid_rst_no_valid", seen, 0);
        run_op(12'h040, 12'h020, 1'b0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
